// File: rtl/rv_csr_sequencer_pkg.sv
// Shared types for the Zicsr sequencer: funct3 encodings, FSM states
// and the read-only address test.
package rv_csr_pkg;

  typedef enum logic [2:0] {
    OP_ILL0 = 3'b000,
    OP_RW   = 3'b001,
    OP_RS   = 3'b010,
    OP_RC   = 3'b011,
    OP_ILL4 = 3'b100,
    OP_RWI  = 3'b101,
    OP_RSI  = 3'b110,
    OP_RCI  = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } seq_state_t;

  function automatic logic csr_is_read_only(
    input logic [11:0] addr
  );
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/rv_csr_sequencer_if.sv
// Decode request, CSR file strobe and writeback response bundle.
// slave = sequencer side, master = decode/CSR-file/writeback side.
interface rv_csr_sequencer_if #(
  parameter bit rv64 = 1'b1
);
  localparam int xlen = rv64 ? 64 : 32;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_csr;
  logic [4:0]      req_rd;
  logic [4:0]      req_rs1;
  logic [xlen-1:0] req_rs1_value;

  logic [11:0]     csr_addr;
  logic            csr_load;
  logic            csr_store;
  logic [xlen-1:0] csr_store_value;
  logic            csr_sigill;
  logic [xlen-1:0] csr_load_value;

  logic            resp_valid;
  logic            resp_ready;
  logic [4:0]      resp_rd;
  logic [xlen-1:0] resp_value;
  logic            resp_write_rd;
  logic            resp_sigill;

  modport slave (
    input  req_valid, req_op, req_csr,
    input  req_rd, req_rs1, req_rs1_value,
    output req_ready,
    output csr_addr, csr_load, csr_store,
    output csr_store_value,
    input  csr_sigill, csr_load_value,
    output resp_valid, resp_rd, resp_value,
    output resp_write_rd, resp_sigill,
    input  resp_ready
  );

  modport master (
    output req_valid, req_op, req_csr,
    output req_rd, req_rs1, req_rs1_value,
    input  req_ready,
    input  csr_addr, csr_load, csr_store,
    input  csr_store_value,
    output csr_sigill, csr_load_value,
    input  resp_valid, resp_rd, resp_value,
    input  resp_write_rd, resp_sigill,
    output resp_ready
  );

endinterface

// File: rtl/rv_csr_sequencer_rmw.sv
// Combinational CSR read-modify-write value: RW -> src,
// RS -> old|src, RC -> old&~src. Ports: op_i, old_i, src_i, new_o.
module rv_csr_rmw
  import rv_csr_pkg::*;
#(
  parameter int xlen = 64
) (
  input  csr_op_t         op_i,
  input  logic [xlen-1:0] old_i,
  input  logic [xlen-1:0] src_i,
  output logic [xlen-1:0] new_o
);

  logic is_set;
  logic is_clr;

  assign is_set = op_i[1:0] == 2'b10;
  assign is_clr = op_i[1:0] == 2'b11;

  always_comb begin
    new_o = src_i;
    unique case (1'b1)
      is_set:  new_o = old_i | src_i;
      is_clr:  new_o = old_i & ~src_i;
      default: new_o = src_i;
    endcase
  end

endmodule

// File: rtl/rv_csr_sequencer.sv
// Zicsr sequencer: IDLE -> [READ] -> [WRITE] -> RESP, one op in flight.
// Ports: clock, reset (async, active-low), bus (slave modport).
module rv_csr_sequencer
  import rv_csr_pkg::*;
#(
  parameter bit rv64 = 1'b1
) (
  input  logic clock,
  input  logic reset,
  rv_csr_sequencer_if.slave bus
);

  localparam int xlen = rv64 ? 64 : 32;

  seq_state_t      state_q, state_d;
  csr_op_t         op_q, op_d;
  logic [11:0]     csr_q, csr_d;
  logic [4:0]      rd_q, rd_d;
  logic [xlen-1:0] src_q, src_d;
  logic [xlen-1:0] old_q, old_d;
  logic            nrd_q, nrd_d;
  logic            nwr_q, nwr_d;
  logic            ill_q, ill_d;

  logic [xlen-1:0] rmw_new;

  rv_csr_rmw #(.xlen(xlen)) u_rmw (
    .op_i  (op_q),
    .old_i (old_q),
    .src_i (src_q),
    .new_o (rmw_new)
  );

  logic is_rw_req;
  logic is_imm_req;
  logic is_ill_req;

  assign is_rw_req  = bus.req_op[1:0] == 2'b01;
  assign is_imm_req = bus.req_op[2];
  assign is_ill_req = bus.req_op[1:0] == 2'b00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ILL0;
      csr_q   <= '0;
      rd_q    <= '0;
      src_q   <= '0;
      old_q   <= '0;
      nrd_q   <= 1'b0;
      nwr_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      csr_q   <= csr_d;
      rd_q    <= rd_d;
      src_q   <= src_d;
      old_q   <= old_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    csr_d   = csr_q;
    rd_d    = rd_q;
    src_d   = src_q;
    old_d   = old_q;
    nrd_d   = nrd_q;
    nwr_d   = nwr_q;
    ill_d   = ill_q;

    bus.req_ready       = 1'b0;
    bus.csr_addr        = '0;
    bus.csr_load        = 1'b0;
    bus.csr_store       = 1'b0;
    bus.csr_store_value = '0;
    bus.resp_valid      = 1'b0;
    bus.resp_rd         = '0;
    bus.resp_value      = '0;
    bus.resp_write_rd   = 1'b0;
    bus.resp_sigill     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d  = csr_op_t'(bus.req_op);
          csr_d = bus.req_csr;
          rd_d  = bus.req_rd;
          src_d = is_imm_req
                ? {{(xlen-5){1'b0}}, bus.req_rs1}
                : bus.req_rs1_value;
          old_d = '0;
          nrd_d = !(is_rw_req && bus.req_rd == 5'd0);
          nwr_d = is_rw_req || bus.req_rs1 != 5'd0;
          ill_d = is_ill_req;
          if (is_ill_req)
            state_d = S_RESP;
          else if (!(is_rw_req && bus.req_rd == 5'd0))
            state_d = S_READ;
          else
            state_d = S_WRITE;
        end
      end
      S_READ: begin
        bus.csr_load = 1'b1;
        bus.csr_addr = csr_q;
        old_d = bus.csr_load_value;
        ill_d = bus.csr_sigill;
        if (bus.csr_sigill) begin
          state_d = S_RESP;
        end else if (nwr_q && csr_is_read_only(csr_q)) begin
          ill_d   = 1'b1;
          state_d = S_RESP;
        end else if (nwr_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        bus.csr_addr = csr_q;
        state_d = S_RESP;
        // Only a write-only entry still needs the read-only test;
        // the READ path has already applied it.
        if (!nrd_q && csr_is_read_only(csr_q)) begin
          ill_d = 1'b1;
        end else begin
          bus.csr_store       = 1'b1;
          bus.csr_store_value = rmw_new;
          ill_d = ill_q | bus.csr_sigill;
        end
      end
      S_RESP: begin
        bus.resp_valid    = 1'b1;
        bus.resp_rd       = rd_q;
        bus.resp_value    = old_q;
        bus.resp_sigill   = ill_q;
        bus.resp_write_rd = !ill_q && nrd_q
                          && rd_q != 5'd0;
        if (bus.resp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/rv_csr_sequencer.md
Name: rv_csr_sequencer

Overview:
- Sequences Zicsr instructions (CSRRW/RS/RC and immediate forms) from decode into the combinational CSR file.
- Per instruction: optional read phase, read-modify-write value computation, optional write phase, then a response to writeback.
- Applies the architectural read/write suppression rules and converts illegal accesses into sigill.
- Sits between decode/execute and the CSR file; exactly one CSR instruction is in flight at a time.

Parameters:
- rv64, 1, 1 selects RV64 (xlen=64), 0 selects RV32 (xlen=32).
- xlen, derived (localparam), rv64 ? 64 : 32.

Ports:
- clock  in  1  single clock, posedge.
- reset  in  1  asynchronous, active-low (asserted when 0).
- req_valid  in  1  instruction offered.
- req_ready  out  1  sequencer can accept.
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- req_csr  in  12  CSR address.
- req_rd  in  5  destination register.
- req_rs1  in  5  rs1 index, or zimm for the I forms.
- req_rs1_value  in  xlen  rs1 value; ignored for the I forms.
- csr_addr  out  12  CSR file address.
- csr_load  out  1  CSR file read strobe.
- csr_store  out  1  CSR file write strobe.
- csr_store_value  out  xlen  write data.
- csr_sigill  in  1  CSR file illegal indication; combinational, same cycle as the strobe.
- csr_load_value  in  xlen  CSR file read data; combinational.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts.
- resp_rd  out  5  destination register.
- resp_value  out  xlen  old CSR value.
- resp_write_rd  out  1  writeback must update rd.
- resp_sigill  out  1  raise illegal-instruction exception.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (reset==0, asynchronous): state goes to IDLE. All outputs 0 except req_ready=1. Latched fields are cleared. A reset mid-operation aborts it: no strobe is issued afterwards and no response is produced.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, csr, rd, rs1, and src. src = zero-extended zimm for I forms, otherwise req_rs1_value.
  - Compute need_read = !(op in {RW,RWI} && rd==0).
  - Compute need_write = op in {RW,RWI} || rs1!=0.
  - Next state:
    - illegal op: RESP with sigill=1.
    - need_read: READ.
    - otherwise (need_write is then always true): WRITE.
- READ (1 cycle):
  - csr_load=1, csr_addr=latched csr.
  - Capture old=csr_load_value and sigill=csr_sigill.
  - If sigill: go to RESP, WRITE skipped.
  - Else if need_write and csr[11:10]==2'b11 (read-only CSR): set sigill and go to RESP without a store.
  - Else if need_write: go to WRITE.
  - Else: go to RESP.
- WRITE (1 cycle), entered from IDLE or READ:
  - If entered from IDLE and csr[11:10]==2'b11: set sigill and go to RESP with no strobe.
  - Otherwise assert csr_store=1 with csr_store_value:
    - RW/RWI: src.
    - RS/RSI: old | src.
    - RC/RCI: old & ~src.
  - old is 0 when READ was skipped; this only occurs for RW/RWI, which do not use old.
  - Capture sigill |= csr_sigill, then go to RESP.
- RESP:
  - resp_valid=1. resp_rd=latched rd. resp_value=old.
  - resp_sigill=sigill.
  - resp_write_rd = !sigill && need_read && rd!=0.
  - All resp_* outputs hold stable until resp_ready. On resp_ready, go to IDLE.
- Strobe rules:
  - csr_load and csr_store are never high in the same cycle.
  - csr_store_value=0 whenever csr_store=0.
  - csr_addr=0 outside READ/WRITE.
- req_ready=0 in every state except IDLE. Back-to-back instructions therefore have one IDLE cycle between responses.
- Latency, accept edge to resp_valid:
  - 1 cycle: illegal op.
  - 2 cycles: read-only or write-only access.
  - 3 cycles: read then write.
- Arithmetic is xlen wide. zimm is zero-extended to xlen.

Decomposition:
- Package rv_csr_pkg:
  - csr_op_t enum for the funct3 encodings.
  - seq_state_t enum.
  - Function csr_is_read_only(addr), returning addr[11:10]==2'b11.
- Sub-module rv_csr_rmw: combinational; inputs op, old, src; output new value. It is reused later by a pipelined CSR path.

Test Plan:
- CSRRS with rd=5, rs1=0, csr=0xC00, cycle=0x10:
  - Exactly one csr_load, no csr_store.
  - resp_value=0x10, resp_write_rd=1, resp_sigill=0, resp_valid 2 cycles after accept.
- CSRRW with rd=0, rs1 value 0xAB, csr=0x340 (CSR file flags sigill on store):
  - No load; one store with value 0xAB.
  - resp_sigill=1, resp_write_rd=0.
- CSRRSI with zimm=3, csr=0xC02:
  - Load, then sigill raised from the read-only check; no store.
  - resp_sigill=1.
- CSRRC with old value 0xFF, src 0x0F (CSR file accepts the store):
  - csr_store_value=0xF0, resp_value=0xFF.
- req_op=000:
  - No strobes; resp_valid 1 cycle after accept with resp_sigill=1.
  - resp_ready held low for 4 cycles: outputs stay stable and req_ready stays 0.
- Reset driven low during WRITE:
  - Outputs clear immediately, state returns to IDLE, no response.
  - A new request after reset is released is handled normally.
